inv_sqrt_arbiter: RTL and testbench

- Shares one pipelined inv_sqrt unit (Q8.24, fixed latency, no backpressure) between NUM_REQ ray-marcher lanes that need vector normalisation.
- Grants at most one request per cycle using round-robin arbitration and drives the unit's input.
- Carries a requester-ID tag down a shift pipeline matched to the unit latency, then routes each result back to its owner.
- Provides a drain sequence so the scheduler can quiesce the unit before a frame or config change.

---
 rtl/inv_sqrt_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_inv_sqrt_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// inv_sqrt_arbiter
//
// Shares one pipelined inv_sqrt unit (Q8.24, fixed latency, no backpressure)
// between NUM_REQ ray-marcher lanes. A round-robin arbiter grants at most one
// lane per cycle. The grant is registered into the unit's input, and a
// requester-ID tag travels down a shift pipeline matched to the unit latency,
// so each result can be routed back to its owner. A drain sequence lets the
// scheduler quiesce the unit before a frame or configuration change.
//
// Optional feature (compile-time macro ISQ_ZERO_BYPASS_EN):
//   When defined, a granted request with x == 0 is not sent to the unit.
//   Its tag carries byp=1, and it returns the saturated value 0x7FFFFFFF with
//   the same latency as a real result, so ordering is preserved.
//   When undefined, x == 0 is issued normally and the tag has no byp bit.
//
// Ports:
//   clk            clock
//   rst            asynchronous reset, active-low
//   req_valid      per-lane request
//   req_x          per-lane operand, lane i at [i*WIDTH +: WIDTH]
//   req_ready      one-hot grant (combinational, depends on req_valid)
//   resp_valid     one-hot result strobe (lanes always accept)
//   resp_data      result, shared by all lanes (holds between responses)
//   isq_valid_in   to inv_sqrt valid_in
//   isq_x          to inv_sqrt x (holds when nothing is issued)
//   isq_valid_out  from inv_sqrt valid_out
//   isq_result     from inv_sqrt result
//   drain_req      stop granting and empty the pipeline
//   drain_done     high while drained
//   busy           requests in flight
//   err_sync       sticky: tag pipeline and unit valid disagreed
// -----------------------------------------------------------------------------
module inv_sqrt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_x,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     isq_valid_in,
    output logic [WIDTH-1:0]         isq_x,
    input  logic                     isq_valid_out,
    input  logic [WIDTH-1:0]         isq_result,
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic                     busy,
    output logic                     err_sync
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_DRAIN,
        ST_DRAINED
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               isq_valid_in_q, isq_valid_in_d;
    logic [WIDTH-1:0]   isq_x_q, isq_x_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]   resp_data_q, resp_data_d;
    logic               err_sync_q, err_sync_d;

    // Tag pipeline: stage 0 is written at the handshake, stage LATENCY is the
    // head and lines up with isq_valid_out of the same transaction.
    logic               tag_v_q  [0:LATENCY];
    logic               tag_v_d  [0:LATENCY];
    logic [ID_W-1:0]    tag_id_q [0:LATENCY];
    logic [ID_W-1:0]    tag_id_d [0:LATENCY];
`ifdef ISQ_ZERO_BYPASS_EN
    logic               tag_byp_q [0:LATENCY];
    logic               tag_byp_d [0:LATENCY];
    localparam logic [WIDTH-1:0] BYP_VAL = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand_id;
    logic [NUM_REQ-1:0] grant_oh;
    logic [WIDTH-1:0]   sel_x;
    logic               hs;
    logic               issue;
    logic               head_v;
    logic [ID_W-1:0]    head_id;
    logic               head_byp;

    // Round-robin search starting one past the last granted lane. Granting
    // stops as soon as drain_req is seen so no new work enters during a drain.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        grant_oh    = '0;
        if (state_q == ST_ACTIVE && !drain_req) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand_id = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (!grant_found && req_valid[cand_id]) begin
                    grant_found = 1'b1;
                    grant_id    = cand_id;
                end
            end
        end
        if (grant_found) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    assign hs     = grant_found;
    assign sel_x  = req_x[int'(grant_id)*WIDTH +: WIDTH];
    assign head_v  = tag_v_q[LATENCY];
    assign head_id = tag_id_q[LATENCY];

`ifdef ISQ_ZERO_BYPASS_EN
    assign issue    = hs && (sel_x != '0);
    assign head_byp = tag_byp_q[LATENCY];
`else
    assign issue    = hs;
    assign head_byp = 1'b0;
`endif

    // Datapath next-state: unit issue, tag shift, response routing,
    // in-flight accounting and the sticky sync-error flag.
    always_comb begin
        isq_valid_in_d = issue;
        isq_x_d        = issue ? sel_x : isq_x_q;
        rr_ptr_d       = hs ? grant_id : rr_ptr_q;

        tag_v_d[0]  = hs;
        tag_id_d[0] = grant_id;
        for (int i = 1; i <= LATENCY; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
`ifdef ISQ_ZERO_BYPASS_EN
        tag_byp_d[0] = hs && (sel_x == '0);
        for (int i = 1; i <= LATENCY; i++) begin
            tag_byp_d[i] = tag_byp_q[i-1];
        end
`endif

        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        if (head_v) begin
            resp_valid_d[head_id] = 1'b1;
`ifdef ISQ_ZERO_BYPASS_EN
            resp_data_d = head_byp ? BYP_VAL : isq_result;
`else
            resp_data_d = isq_result;
`endif
        end

        // A response leaves the count at the head cycle, when it is registered.
        inflight_d = inflight_q;
        if (hs && !head_v) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!hs && head_v) begin
            inflight_d = inflight_q - CNT_W'(1);
        end

        // A result arriving without a matching tag (or a tag with no result)
        // means the unit and the pipeline have lost alignment.
        err_sync_d = err_sync_q | ((head_v & ~head_byp) != isq_valid_out);
    end

    // Drain FSM. Leaving DRAINED only needs drain_req low; granting resumes
    // the cycle after that.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: begin
                if (drain_req) begin
                    state_d = (inflight_q == '0) ? ST_DRAINED : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = ST_DRAINED;
                end
            end
            ST_DRAINED: begin
                if (!drain_req) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_ACTIVE;
            rr_ptr_q       <= ID_W'(NUM_REQ - 1);
            inflight_q     <= '0;
            isq_valid_in_q <= 1'b0;
            isq_x_q        <= '0;
            resp_valid_q   <= '0;
            resp_data_q    <= '0;
            err_sync_q     <= 1'b0;
            for (int i = 0; i <= LATENCY; i++) begin
                tag_v_q[i]  <= 1'b0;
                tag_id_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            inflight_q     <= inflight_d;
            isq_valid_in_q <= isq_valid_in_d;
            isq_x_q        <= isq_x_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            err_sync_q     <= err_sync_d;
            for (int i = 0; i <= LATENCY; i++) begin
                tag_v_q[i]  <= tag_v_d[i];
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

`ifdef ISQ_ZERO_BYPASS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                tag_byp_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i <= LATENCY; i++) begin
                tag_byp_q[i] <= tag_byp_d[i];
            end
        end
    end
`endif

    assign req_ready    = grant_oh;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign isq_valid_in = isq_valid_in_q;
    assign isq_x        = isq_x_q;
    assign drain_done   = (state_q == ST_DRAINED);
    assign busy         = (inflight_q != '0);
    assign err_sync     = err_sync_q;

endmodule

// File: tb/tb_inv_sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inv_sqrt_arbiter
//
// Drives inv_sqrt_arbiter together with a stand-in inv_sqrt unit (a fixed
// LATENCY-deep pipe applying a scrambling function, so routing errors show
// up as wrong data). A transaction-level reference model tracks expected
// grants (round-robin over requesting lanes), outstanding transactions as a
// queue of {due cycle, lane, data}, the drain mode and the sticky error flag,
// and every DUT output is compared each cycle.
// -----------------------------------------------------------------------------
module tb_inv_sqrt_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int LATENCY = 3;
`ifdef ISQ_ZERO_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_x;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         resp_data;
    logic                     isq_valid_in;
    logic [WIDTH-1:0]         isq_x;
    logic                     isq_valid_out;
    logic [WIDTH-1:0]         isq_result;
    logic                     drain_req;
    logic                     drain_done;
    logic                     busy;
    logic                     err_sync;
    logic                     force_out;

    inv_sqrt_arbiter #(
        .NUM_REQ(NUM_REQ),
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_x        (req_x),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .isq_valid_in (isq_valid_in),
        .isq_x        (isq_x),
        .isq_valid_out(isq_valid_out),
        .isq_result   (isq_result),
        .drain_req    (drain_req),
        .drain_done   (drain_done),
        .busy         (busy),
        .err_sync     (err_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the inv_sqrt unit: a recognisable function of x, so a
    // result routed to the wrong lane or taken from the wrong slot is visible.
    function automatic logic [WIDTH-1:0] unitFn(input logic [WIDTH-1:0] x);
        return {x[15:0], x[31:16]} ^ 32'h5A5A0F0F;
    endfunction

    // Stand-in unit pipeline, cleared by the shared reset.
    logic [LATENCY-1:0] u_v;
    logic [WIDTH-1:0]   u_x [LATENCY];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_v <= '0;
            for (int i = 0; i < LATENCY; i++) u_x[i] <= '0;
        end else begin
            u_v    <= {u_v[LATENCY-2:0], isq_valid_in};
            u_x[0] <= isq_x;
            for (int i = 1; i < LATENCY; i++) u_x[i] <= u_x[i-1];
        end
    end

    assign isq_valid_out = u_v[LATENCY-1] | force_out;
    assign isq_result    = unitFn(u_x[LATENCY-1]);

    // Reference model state
    typedef struct {
        int               due;
        int               lane;
        logic [WIDTH-1:0] data;
        bit               byp;
    } exp_t;

    typedef enum {M_ACTIVE, M_DRAIN, M_DRAINED} mode_t;

    exp_t             sb[$];
    mode_t            m_mode;
    int               m_last;
    logic             m_iv;
    logic [WIDTH-1:0] m_ix;
    logic [WIDTH-1:0] m_rdata;
    logic             m_err;
    int               cyc;

    // Lane stimulus: a pending lane keeps its operand until it is granted.
    bit               pend [NUM_REQ];
    logic [WIDTH-1:0] px   [NUM_REQ];

    int unsigned checks;
    int unsigned errors;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic modelReset();
        sb.delete();
        m_mode  = M_ACTIVE;
        m_last  = NUM_REQ - 1;
        m_iv    = 1'b0;
        m_ix    = '0;
        m_rdata = '0;
        m_err   = 1'b0;
        cyc     = 0;
        for (int l = 0; l < NUM_REQ; l++) begin
            pend[l] = 1'b0;
            px[l]   = '0;
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        req_x     = '0;
        drain_req = 1'b0;
        force_out = 1'b0;
        #1;
        checkOutput("rst_req_ready",  64'(req_ready),    64'(0));
        checkOutput("rst_resp_valid", 64'(resp_valid),   64'(0));
        checkOutput("rst_resp_data",  64'(resp_data),    64'(0));
        checkOutput("rst_isq_valid",  64'(isq_valid_in), 64'(0));
        checkOutput("rst_isq_x",      64'(isq_x),        64'(0));
        checkOutput("rst_drain_done", 64'(drain_done),   64'(0));
        checkOutput("rst_busy",       64'(busy),         64'(0));
        checkOutput("rst_err_sync",   64'(err_sync),     64'(0));
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic raiseLane(input int l, input logic [WIDTH-1:0] x);
        if (!pend[l]) begin
            pend[l] = 1'b1;
            px[l]   = x;
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare every output
    // against the model, then advance the model across the next rising edge.
    task automatic applyStimulus(input logic drn, input logic frc);
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] exp_rv;
        logic [WIDTH-1:0]   gx;
        exp_t               keep[$];
        exp_t               e;
        int                 g;
        int                 l;
        bit                 head_exp;
        bit                 byp;

        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]              = pend[i];
            req_x[i*WIDTH +: WIDTH]   = px[i];
        end
        drain_req = drn;
        force_out = frc;
        #1;

        exp_ready = '0;
        g = -1;
        if (m_mode == M_ACTIVE && !drn) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                l = (m_last + k) % NUM_REQ;
                if (g < 0 && pend[l]) g = l;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;

        exp_rv = '0;
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                exp_rv[sb[i].lane] = 1'b1;
                m_rdata = sb[i].data;
            end
        end

        checkOutput("req_ready",    64'(req_ready),    64'(exp_ready));
        checkOutput("resp_valid",   64'(resp_valid),   64'(exp_rv));
        checkOutput("resp_data",    64'(resp_data),    64'(m_rdata));
        checkOutput("isq_valid_in", 64'(isq_valid_in), 64'(m_iv));
        checkOutput("isq_x",        64'(isq_x),        64'(m_ix));
        checkOutput("drain_done",   64'(drain_done),   64'(m_mode == M_DRAINED));
        checkOutput("err_sync",     64'(err_sync),     64'(m_err));

        keep = {};
        head_exp = 1'b0;
        foreach (sb[i]) begin
            if (sb[i].due > cyc) keep.push_back(sb[i]);
            if (sb[i].due == cyc + 1 && !sb[i].byp) head_exp = 1'b1;
        end
        sb = keep;
        checkOutput("busy", 64'(busy), 64'(sb.size() != 0));

        if (frc && !head_exp) m_err = 1'b1;

        case (m_mode)
            M_ACTIVE:  if (drn) m_mode = (sb.size() == 0) ? M_DRAINED : M_DRAIN;
            M_DRAIN:   if (sb.size() == 0) m_mode = M_DRAINED;
            default:   if (!drn) m_mode = M_ACTIVE;
        endcase

        m_iv = 1'b0;
        if (g >= 0) begin
            gx  = px[g];
            byp = BYP_EN && (gx == '0);
            e.due  = cyc + LATENCY + 2;
            e.lane = g;
            e.data = byp ? 32'h7FFFFFFF : unitFn(gx);
            e.byp  = byp;
            sb.push_back(e);
            if (!byp) begin
                m_iv = 1'b1;
                m_ix = gx;
            end
            m_last  = g;
            pend[g] = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    logic drn_r;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        req_valid = '0;
        req_x     = '0;
        drain_req = 1'b0;
        force_out = 1'b0;
        modelReset();
        applyReset();

        $display("[TB] single request on lane 1");
        raiseLane(1, 32'h04000000);
        idle(8);

        $display("[TB] all lanes requesting continuously");
        for (int c = 0; c < 12; c++) begin
            for (int l = 0; l < NUM_REQ; l++) raiseLane(l, $urandom);
            applyStimulus(1'b0, 1'b0);
        end
        idle(7);

        $display("[TB] lanes 0 and 2, then lane 0 alone");
        for (int c = 0; c < 4; c++) begin
            raiseLane(0, $urandom);
            raiseLane(2, $urandom);
            applyStimulus(1'b0, 1'b0);
        end
        for (int c = 0; c < 4; c++) begin
            raiseLane(0, $urandom);
            applyStimulus(1'b0, 1'b0);
        end
        idle(7);

        $display("[TB] drain with requests in flight");
        for (int c = 0; c < 3; c++) begin
            for (int l = 0; l < NUM_REQ; l++) raiseLane(l, $urandom);
            applyStimulus(1'b0, 1'b0);
        end
        for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b0);
        idle(10);

        $display("[TB] spurious unit valid, then reset mid-stream");
        applyStimulus(1'b0, 1'b1);
        idle(4);
        for (int c = 0; c < 3; c++) begin
            raiseLane(c, $urandom);
            applyStimulus(1'b0, 1'b0);
        end
        applyReset();
        idle(3);

        $display("[TB] zero operand between two lane 1 requests");
        raiseLane(1, 32'h01000000);
        applyStimulus(1'b0, 1'b0);
        raiseLane(3, 32'h00000000);
        applyStimulus(1'b0, 1'b0);
        raiseLane(1, 32'h01000000);
        idle(9);

        $display("[TB] randomized traffic with drain episodes");
        drn_r = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < NUM_REQ; l++) begin
                if ($urandom_range(0, 1) == 1)
                    raiseLane(l, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom);
            end
            if ($urandom_range(0, 29) == 0) drn_r = !drn_r;
            applyStimulus(drn_r, 1'b0);
        end
        for (int l = 0; l < NUM_REQ; l++) pend[l] = 1'b0;
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
